// File: rtl/count_sched_if.sv
// Bundle between the shared-counter scheduler, its requesters and the external up-counter.
interface count_sched_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] len;
    logic [W-1:0]      cnt_val;
    logic              cnt_clr;
    logic              cnt_en;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              busy;

    // Requester / counter side
    modport master (
        output req, len, cnt_val,
        input  cnt_clr, cnt_en, gnt, done, busy
    );

    // Scheduler side
    modport slave (
        input  req, len, cnt_val,
        output cnt_clr, cnt_en, gnt, done, busy
    );
endinterface

// File: rtl/count_sched.sv
// Round-robin scheduler granting one shared up-counter to NREQ requesters,
// each run counting from 0 up to the owner's latched terminal length.
module count_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8
) (
    input  logic         clk,
    input  logic         reset,
    count_sched_if.slave bus
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [W-1:0]      len_q, len_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              cnt_clr_q, cnt_clr_d;
    logic              busy_q;

    logic              pick_valid_c;
    logic [IW-1:0]     pick_idx_c;
    logic [W-1:0]      pick_len_c;
    logic              owner_req_c;
    logic              at_len_c;

    // Round-robin search starting just after the last granted index
    always_comb begin
        int unsigned idx;
        pick_valid_c = 1'b0;
        pick_idx_c   = ptr_q;
        idx          = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!pick_valid_c && bus.req[IW'(idx)]) begin
                pick_valid_c = 1'b1;
                pick_idx_c   = IW'(idx);
            end
        end
    end

    always_comb begin
        pick_len_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_idx_c == IW'(i)) pick_len_c = bus.len[i*W +: W];
        end
    end

    // ptr_q doubles as the owner index while busy
    assign owner_req_c = bus.req[ptr_q];
    assign at_len_c    = (bus.cnt_val == len_q);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        len_d     = len_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        cnt_clr_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid_c) begin
                    state_d   = CLEAR;
                    ptr_d     = pick_idx_c;
                    len_d     = pick_len_c;
                    gnt_d     = NREQ'(1) << pick_idx_c;
                    cnt_clr_d = 1'b1;
                end
            end
            CLEAR: begin
                if (!owner_req_c) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // An abort takes priority over reaching the terminal count
                if (!owner_req_c) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else if (at_len_c) begin
                    state_d = DONE;
                    done_d  = gnt_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= IW'(NREQ - 1);
            len_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            cnt_clr_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            len_q     <= len_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            cnt_clr_q <= cnt_clr_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    assign bus.cnt_clr = cnt_clr_q;
    assign bus.cnt_en  = (state_q == RUN) && owner_req_c && !at_len_c;
    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_count_sched.sv
// Directed bench for count_sched with a behavioural model of the shared up-counter.
module tb_count_sched;
    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 8;

    logic clk;
    logic reset;
    logic [W-1:0] cnt_m = 8'h55;
    int n_assert = 0;
    int n_fail   = 0;
    int inv_err  = 0;
    int done_cnt [NREQ];

    count_sched_if #(.NREQ(NREQ), .W(W)) bus ();

    count_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External shared counter
    always @(posedge clk) begin
        if (bus.cnt_clr)     cnt_m <= '0;
        else if (bus.cnt_en) cnt_m <= cnt_m + 8'd1;
    end
    assign bus.cnt_val = cnt_m;

    // Grant/done sanity and done-pulse tally, sampled mid-cycle
    always @(negedge clk) begin
        if ($countones(bus.gnt) > 1 || $countones(bus.done) > 1 || (bus.done & ~bus.gnt) != '0)
            inv_err++;
        for (int i = 0; i < NREQ; i++) if (bus.done[i]) done_cnt[i]++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_done();
        for (int i = 0; i < NREQ; i++) done_cnt[i] = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int ncyc;
        int en_cnt;
        logic [3:0] order [5];
        order[0] = 4'd0; order[1] = 4'd1; order[2] = 4'd2; order[3] = 4'd3; order[4] = 4'd0;
        clr_done();
        reset   = 1'b0;
        bus.req = '0;
        bus.len = '0;
        tick();
        chk("rst_gnt",  32'(bus.gnt), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_clr",  32'(bus.cnt_clr), 0);
        chk("rst_en",   32'(bus.cnt_en), 0);
        reset = 1'b1;
        tick();

        // Single request, L=3 on requester 2
        bus.len = {8'd9, 8'd3, 8'd9, 8'd9};
        bus.req = 4'b0100;
        tick();
        chk("t1_gnt",   32'(bus.gnt), 4);
        chk("t1_clr",   32'(bus.cnt_clr), 1);
        chk("t1_en0",   32'(bus.cnt_en), 0);
        chk("t1_busy0", 32'(bus.busy), 1);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t1_run_cnt", 32'(bus.cnt_val), 32'(c));
            chk("t1_run_en",  32'(bus.cnt_en), (c < 3) ? 1 : 0);
            chk("t1_run_clr", 32'(bus.cnt_clr), 0);
            chk("t1_run_bsy", 32'(bus.busy), 1);
        end
        tick();
        chk("t1_done",   32'(bus.done), 4);
        chk("t1_dgnt",   32'(bus.gnt), 4);
        chk("t1_dcnt",   32'(bus.cnt_val), 3);
        chk("t1_dbusy",  32'(bus.busy), 1);
        bus.req = '0;
        tick();
        chk("t1_idle_gnt",  32'(bus.gnt), 0);
        chk("t1_idle_done", 32'(bus.done), 0);
        chk("t1_idle_busy", 32'(bus.busy), 0);
        tick();
        chk("t1_ndone", 32'(done_cnt[2]), 1);

        // All four requesting, L=1 each, round-robin order from requester 0
        do_reset();
        clr_done();
        bus.len = {8'd1, 8'd1, 8'd1, 8'd1};
        bus.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk("rr_gnt",  32'(bus.gnt), 32'(1) << order[g]);
            chk("rr_clr",  32'(bus.cnt_clr), 1);
            tick();
            chk("rr_en_a", 32'(bus.cnt_en), 1);
            tick();
            chk("rr_en_b", 32'(bus.cnt_en), 0);
            tick();
            chk("rr_done", 32'(bus.done), 32'(1) << order[g]);
            if (g == 4) bus.req = '0;
            tick();
            chk("rr_idle_gnt",  32'(bus.gnt), 0);
            chk("rr_idle_busy", 32'(bus.busy), 0);
        end
        tick();
        chk("rr_nd0", 32'(done_cnt[0]), 2);
        chk("rr_nd1", 32'(done_cnt[1]), 1);
        chk("rr_nd2", 32'(done_cnt[2]), 1);
        chk("rr_nd3", 32'(done_cnt[3]), 1);

        // L=0 on requester 1
        do_reset();
        clr_done();
        bus.len = {8'd7, 8'd7, 8'd0, 8'd7};
        bus.req = 4'b0010;
        tick();
        chk("z_gnt", 32'(bus.gnt), 2);
        chk("z_clr", 32'(bus.cnt_clr), 1);
        tick();
        chk("z_run_en",  32'(bus.cnt_en), 0);
        chk("z_run_cnt", 32'(bus.cnt_val), 0);
        tick();
        chk("z_done", 32'(bus.done), 2);
        bus.req = '0;
        tick();
        chk("z_idle", 32'(bus.busy), 0);

        // L=255 on requester 1: full range without wrap
        bus.len = {8'd7, 8'd7, 8'd255, 8'd7};
        bus.req = 4'b0010;
        tick();
        chk("f_gnt", 32'(bus.gnt), 2);
        tick();
        ncyc = 0;
        en_cnt = 0;
        while (bus.done == '0 && ncyc < 400) begin
            en_cnt += int'(bus.cnt_en);
            tick();
            ncyc++;
        end
        chk("f_timeout", 32'(ncyc < 400), 1);
        chk("f_runcyc",  32'(ncyc), 256);
        chk("f_encnt",   32'(en_cnt), 255);
        chk("f_cntval",  32'(bus.cnt_val), 255);
        chk("f_done",    32'(bus.done), 2);
        bus.req = '0;
        tick();

        // Abort by requester 3 in its 2nd RUN cycle; requester 0 served next
        clr_done();
        bus.len = {8'd5, 8'd7, 8'd7, 8'd4};
        bus.req = 4'b1001;
        tick();
        chk("a_gnt", 32'(bus.gnt), 8);
        bus.len = {8'd1, 8'd1, 8'd1, 8'd1};
        tick();
        chk("a_en1", 32'(bus.cnt_en), 1);
        tick();
        chk("a_cnt2", 32'(bus.cnt_val), 1);
        bus.req = 4'b0001;
        #1;
        chk("a_en_drop", 32'(bus.cnt_en), 0);
        tick();
        chk("a_idle_gnt",  32'(bus.gnt), 0);
        chk("a_idle_busy", 32'(bus.busy), 0);
        chk("a_idle_done", 32'(bus.done), 0);
        chk("a_hold_cnt",  32'(bus.cnt_val), 1);
        tick();
        chk("a_next_gnt", 32'(bus.gnt), 1);
        bus.req = '0;
        tick();
        chk("a_clr_abort", 32'(bus.gnt), 0);
        tick();
        chk("a_nodone3", 32'(done_cnt[3]), 0);
        chk("a_nodone0", 32'(done_cnt[0]), 0);

        // Reset asserted mid-run with L=10
        clr_done();
        bus.len = {8'd2, 8'd2, 8'd2, 8'd10};
        bus.req = 4'b0001;
        tick();
        tick();
        tick();
        tick();
        chk("r_en_before", 32'(bus.cnt_en), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("r_gnt",  32'(bus.gnt), 0);
        chk("r_busy", 32'(bus.busy), 0);
        chk("r_en",   32'(bus.cnt_en), 0);
        chk("r_clr",  32'(bus.cnt_clr), 0);
        chk("r_done", 32'(bus.done), 0);
        tick();
        @(negedge clk);
        reset = 1'b1;
        bus.req = 4'b1010;
        tick();
        chk("r_first_gnt", 32'(bus.gnt), 2);
        bus.req = '0;
        tick();
        tick();
        chk("r_nodone", 32'(done_cnt[0]), 0);

        chk("invariant", 32'(inv_err), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
